// File: rtl/ogege_pkg.sv
// Shared definitions for the text engine: cell layout, palette size and reset colours.
package ogege_pkg;

  localparam int CELL_W      = 8;
  localparam int CELL_H      = 8;
  localparam int CELL_SHIFT  = 3;
  localparam int PAL_ENTRIES = 16;
  localparam int PAL_IDX_W   = 4;
  localparam int CELL_DATA_W = 16;
  localparam int CHAR_LSB    = 8;
  localparam int FG_LSB      = 4;
  localparam int BG_LSB      = 0;
  localparam int MAX_CBITS   = 16;

  typedef struct packed {
    logic [7:0] chr;
    logic [3:0] fg;
    logic [3:0] bg;
  } cell_t;

  // Per-pixel control that travels alongside the cell/font data.
  typedef struct packed {
    logic       de;
    logic       hs;
    logic       vs;
    logic       inr;
    logic       cur;
    logic [2:0] x;
  } ctl_t;

  // Grey ramp: entry i gets level i<<(cbits-4) on every channel, packed {R,G,B}.
  function automatic logic [3*MAX_CBITS-1:0] pal_reset_color(input int idx, input int cbits);
    logic [3*MAX_CBITS-1:0] level;
    level = (3*MAX_CBITS)'(idx) << (cbits - 4);
    return (level << (2 * cbits)) | (level << cbits) | level;
  endfunction

endpackage

// File: rtl/ogege_text_ram.sv
// Simple dual-port cell RAM: one write port, one registered read port (read-before-write).
module ogege_text_ram #(
  parameter int DEPTH = 4800,
  parameter int AW    = 13,
  parameter int DW    = 16
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q;

  // A read of the address being written returns the previous contents.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ogege_text_engine.sv
// Text-mode pixel generator: cell RAM, external font ROM, 16-entry palette and blinking cursor.
// Three register stages keep RGB, DE and syncs aligned.
module ogege_text_engine
  import ogege_pkg::*;
#(
  parameter int  HSZ          = 10,
  parameter int  VSZ          = 9,
  parameter int  COLS         = 80,
  parameter int  ROWS         = 60,
  parameter int  CBITS        = 4,
  parameter int  BLINK_FRAMES = 30,
  parameter bit  SYNC_ACT     = 1'b0,
  parameter bit  WR_ANYTIME   = 1'b0,
  localparam int AW           = $clog2(COLS * ROWS)
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic [HSZ-1:0]     hcount_i,
  input  logic [VSZ-1:0]     vcount_i,
  input  logic               de_i,
  input  logic               hsync_i,
  input  logic               vsync_i,
  input  logic               wr_valid_i,
  output logic               wr_ready_o,
  input  logic [AW-1:0]      wr_addr_i,
  input  logic [15:0]        wr_data_i,
  input  logic               pal_we_i,
  input  logic [3:0]         pal_idx_i,
  input  logic [3*CBITS-1:0] pal_color_i,
  input  logic               cur_en_i,
  input  logic [6:0]         cur_col_i,
  input  logic [5:0]         cur_row_i,
  output logic [10:0]        font_addr_o,
  input  logic [7:0]         font_data_i,
  output logic [CBITS-1:0]   r_o,
  output logic [CBITS-1:0]   g_o,
  output logic [CBITS-1:0]   b_o,
  output logic               hsync_o,
  output logic               vsync_o,
  output logic               de_o
);

  localparam int CW     = HSZ - CELL_SHIFT;
  localparam int RW     = VSZ - CELL_SHIFT;
  localparam int NCELLS = COLS * ROWS;
  localparam int PW     = 3 * CBITS;
  localparam int FCW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam ctl_t CTL_RST = '{de: 1'b0, hs: ~SYNC_ACT, vs: ~SYNC_ACT, inr: 1'b0, cur: 1'b0, x: 3'd0};

  logic [CW-1:0]  col_s0;
  logic [RW-1:0]  row_s0;
  logic           inr_s0;
  logic           cur_hit_s0;
  logic [AW-1:0]  raddr_s0;
  logic           wr_en;
  logic [15:0]    ram_rdata;
  cell_t          cell_s1;

  ctl_t           ctl_s1_d, ctl_s1_q;
  logic [2:0]     y_s1_d, y_s1_q;
  ctl_t           ctl_s2_d, ctl_s2_q;
  logic [3:0]     fg_s2_d, fg_s2_q;
  logic [3:0]     bg_s2_d, bg_s2_q;
  logic [PW-1:0]  rgb_d, rgb_q;
  logic           de_d, de_q;
  logic           hs_d, hs_q;
  logic           vs_d, vs_q;
  logic           vs_prev_d, vs_prev_q;
  logic [FCW-1:0] frame_cnt_d, frame_cnt_q;
  logic           blink_d, blink_q;

  logic           pix_on;
  logic [3:0]     fg_eff;
  logic [3:0]     bg_eff;
  logic [3:0]     pal_sel;
  logic [PW-1:0]  pal_rd [PAL_ENTRIES];

  // S0: cell address and per-pixel control.
  always_comb begin
    col_s0     = hcount_i[HSZ-1:CELL_SHIFT];
    row_s0     = vcount_i[VSZ-1:CELL_SHIFT];
    inr_s0     = (int'(col_s0) < COLS) && (int'(row_s0) < ROWS);
    cur_hit_s0 = (int'(col_s0) == int'(cur_col_i)) && (int'(row_s0) == int'(cur_row_i));
    // Off-screen cells read entry 0 so the RAM index never leaves its range.
    raddr_s0   = inr_s0 ? AW'(int'(row_s0) * COLS + int'(col_s0)) : '0;
    ctl_s1_d   = '{de: de_i, hs: hsync_i, vs: vsync_i, inr: inr_s0,
                   cur: cur_en_i && blink_q && cur_hit_s0, x: hcount_i[CELL_SHIFT-1:0]};
    y_s1_d     = vcount_i[CELL_SHIFT-1:0];
  end

  assign wr_ready_o = WR_ANYTIME | ~de_i;
  assign wr_en      = wr_valid_i && wr_ready_o && (int'(wr_addr_i) < NCELLS);

  ogege_text_ram #(
    .DEPTH (NCELLS),
    .AW    (AW),
    .DW    (CELL_DATA_W)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (wr_en),
    .waddr_i (wr_addr_i),
    .wdata_i (wr_data_i),
    .raddr_i (raddr_s0),
    .rdata_o (ram_rdata)
  );

  // S1: glyph row request to the font ROM; data returns during S2.
  assign cell_s1     = cell_t'(ram_rdata);
  assign font_addr_o = (ctl_s1_q.de && ctl_s1_q.inr) ? {cell_s1.chr, y_s1_q} : '0;

  always_comb begin
    ctl_s2_d = ctl_s1_q;
    fg_s2_d  = cell_s1.fg;
    bg_s2_d  = cell_s1.bg;
  end

  // Palette entries; a write is visible to the S2 lookup on the following cycle.
  for (genvar gi = 0; gi < PAL_ENTRIES; gi++) begin : g_pal
    localparam logic [PW-1:0] RST_COLOR = PW'(pal_reset_color(gi, CBITS));
    logic [PW-1:0] pal_d, pal_q;

    always_comb begin
      pal_d = pal_q;
      if (pal_we_i && (pal_idx_i == PAL_IDX_W'(gi))) begin
        pal_d = pal_color_i;
      end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        pal_q <= RST_COLOR;
      end else begin
        pal_q <= pal_d;
      end
    end

    assign pal_rd[gi] = pal_q;
  end

  // S2: pixel bit select, cursor swap and palette lookup.
  always_comb begin
    pix_on  = font_data_i[3'd7 - ctl_s2_q.x];
    fg_eff  = ctl_s2_q.cur ? bg_s2_q : fg_s2_q;
    bg_eff  = ctl_s2_q.cur ? fg_s2_q : bg_s2_q;
    pal_sel = ctl_s2_q.inr ? (pix_on ? fg_eff : bg_eff) : '0;
    rgb_d   = ctl_s2_q.de ? pal_rd[pal_sel] : '0;
    de_d    = ctl_s2_q.de;
    hs_d    = ctl_s2_q.hs;
    vs_d    = ctl_s2_q.vs;
  end

  // Blink: count frames on vsync entering its active level.
  always_comb begin
    vs_prev_d   = vsync_i;
    frame_cnt_d = frame_cnt_q;
    blink_d     = blink_q;
    if ((vsync_i == SYNC_ACT) && (vs_prev_q != SYNC_ACT)) begin
      if (int'(frame_cnt_q) == BLINK_FRAMES - 1) begin
        frame_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FCW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ctl_s1_q    <= CTL_RST;
      y_s1_q      <= '0;
      ctl_s2_q    <= CTL_RST;
      fg_s2_q     <= '0;
      bg_s2_q     <= '0;
      rgb_q       <= '0;
      de_q        <= 1'b0;
      hs_q        <= ~SYNC_ACT;
      vs_q        <= ~SYNC_ACT;
      vs_prev_q   <= ~SYNC_ACT;
      frame_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else begin
      ctl_s1_q    <= ctl_s1_d;
      y_s1_q      <= y_s1_d;
      ctl_s2_q    <= ctl_s2_d;
      fg_s2_q     <= fg_s2_d;
      bg_s2_q     <= bg_s2_d;
      rgb_q       <= rgb_d;
      de_q        <= de_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      vs_prev_q   <= vs_prev_d;
      frame_cnt_q <= frame_cnt_d;
      blink_q     <= blink_d;
    end
  end

  assign r_o     = rgb_q[PW-1 -: CBITS];
  assign g_o     = rgb_q[2*CBITS-1 -: CBITS];
  assign b_o     = rgb_q[CBITS-1:0];
  assign de_o    = de_q;
  assign hsync_o = hs_q;
  assign vsync_o = vs_q;

endmodule
